seg_scan_display: RTL

Parametrised multiplexed seven-segment driver for the calculator front panel. It replaces the fixed 4-digit, 8-bit display path with the following features:
- configurable digit count, value width and refresh rate;
- a sequential binary-to-BCD converter (double-dabble) with a load/busy handshake;
- optional leading-zero blanking, a floating minus sign, a decimal point and overflow indication.

It sits between the operand/ALU result mux and the board's anode/segment pins.

---
 rtl/seg_scan_display.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Multiplexed seven-segment driver. It converts an unsigned magnitude to BCD
//   with a sequential double-dabble (one iteration per clock), then scans the
//   digits. The display also supports leading-zero blanking, a floating minus
//   sign, an error pattern, a decimal point and overflow dashes.
//
// Ports
//   Clk, Rst  : clock, synchronous active-high reset
//   load      : one-cycle strobe; captures value/mode/dp_pos when not busy
//   value     : unsigned magnitude (DATA_W bits)
//   mode      : 0 plain, 1 negative, 2 error 'E', 3 fixed-point
//   dp_pos    : digit whose decimal point is lit in mode 3
//   blank_lz  : leading-zero blanking enable (live level)
//   busy      : conversion in progress
//   anodes    : active-low digit enables, bit 0 = rightmost digit
//   segments  : active-low {dp,g,f,e,d,c,b,a}
module seg_scan_display #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 12
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      load,
  input  logic [DATA_W-1:0]         value,
  input  logic [1:0]                mode,
  input  logic [$clog2(DIGITS)-1:0] dp_pos,
  input  logic                      blank_lz,
  output logic                      busy,
  output logic [DIGITS-1:0]         anodes,
  output logic [7:0]                segments
);

  localparam int unsigned NB = (DIGITS > (DATA_W + 2) / 3) ? DIGITS : (DATA_W + 2) / 3;
  localparam int unsigned BW = 4 * NB;
  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned CW = $clog2(DATA_W + 1);

  typedef enum logic {S_IDLE, S_CONV} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [1:0]        sh_mode_q, sh_mode_d;
  logic [IW-1:0]     sh_dp_q, sh_dp_d;

  logic [DW-1:0]     disp_bcd_q, disp_bcd_d;
  logic [1:0]        disp_mode_q, disp_mode_d;
  logic [IW-1:0]     disp_dp_q, disp_dp_d;
  logic              disp_ovf_q, disp_ovf_d;

  logic [DIV_W-1:0]  div_q;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] anodes_q, anodes_d;
  logic [7:0]        segments_q, segments_d;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     bcd_step;
  logic [DATA_W-1:0] bin_step;
  logic              ovf_step;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // One double-dabble iteration: add-3 adjust every digit, then shift in the
  // next binary MSB. Overflow is judged on the result of this step because the
  // display registers latch it on the final iteration.
  always_comb begin
    adj = bcd_q;
    for (int unsigned k = 0; k < NB; k++) begin
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    end
    bcd_step = BW'({adj, bin_q[DATA_W-1]});
    bin_step = bin_q << 1;
    ovf_step = 1'b0;
    for (int unsigned k = 0; k < NB; k++) begin
      if (bcd_step[4*k +: 4] != 4'd0) begin
        if ((sh_mode_q == 2'd0 || sh_mode_q == 2'd3) && k >= DIGITS) ovf_step = 1'b1;
        if (sh_mode_q == 2'd1 && k >= DIGITS - 1) ovf_step = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    sh_mode_d   = sh_mode_q;
    sh_dp_d     = sh_dp_q;
    disp_bcd_d  = disp_bcd_q;
    disp_mode_d = disp_mode_q;
    disp_dp_d   = disp_dp_q;
    disp_ovf_d  = disp_ovf_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d   = S_CONV;
          cnt_d     = CW'(DATA_W);
          bin_d     = value;
          bcd_d     = '0;
          sh_mode_d = mode;
          sh_dp_d   = dp_pos;
        end
      end
      default: begin
        bin_d = bin_step;
        bcd_d = bcd_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d     = S_IDLE;
          disp_bcd_d  = bcd_step[DW-1:0];
          disp_mode_d = sh_mode_q;
          disp_dp_d   = sh_dp_q;
          disp_ovf_d  = ovf_step;
        end
      end
    endcase
  end

  // Segments are computed for the index the scan will hold after this edge,
  // so anodes and segments always switch together.
  always_comb begin
    logic [IW-1:0] msd;
    logic [3:0]    dig;
    logic [7:0]    pat;
    idx_d = idx_q;
    if (div_q == '1) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    anodes_d = ~(DIGITS'(1) << idx_d);

    msd = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (disp_bcd_q[4*k +: 4] != 4'd0) msd = IW'(k);
    end
    dig = disp_bcd_q[4*idx_d +: 4];
    pat = 8'hFF;
    if (disp_ovf_q) begin
      pat = 8'hBF;
    end else begin
      case (disp_mode_q)
        2'd0: pat = (blank_lz && idx_d > msd) ? 8'hFF : seg7(dig);
        2'd1: begin
          if (!blank_lz)
            pat = (idx_d == IW'(DIGITS - 1)) ? 8'hBF : seg7(dig);
          else if ({1'b0, idx_d} > {1'b0, msd} + 1'b1)
            pat = 8'hFF;
          else if ({1'b0, idx_d} == {1'b0, msd} + 1'b1)
            pat = 8'hBF;
          else
            pat = seg7(dig);
        end
        2'd2: pat = (idx_d == IW'(DIGITS - 1)) ? 8'h86 : 8'hFF;
        default: begin
          pat = (blank_lz && idx_d > msd && idx_d > disp_dp_q) ? 8'hFF : seg7(dig);
          if (idx_d == disp_dp_q) pat = pat & 8'h7F;
        end
      endcase
    end
    segments_d = pat;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      sh_mode_q   <= '0;
      sh_dp_q     <= '0;
      disp_bcd_q  <= '0;
      disp_mode_q <= '0;
      disp_dp_q   <= '0;
      disp_ovf_q  <= 1'b0;
      div_q       <= '0;
      idx_q       <= '0;
      anodes_q    <= ~(DIGITS'(1));
      segments_q  <= 8'hC0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      sh_mode_q   <= sh_mode_d;
      sh_dp_q     <= sh_dp_d;
      disp_bcd_q  <= disp_bcd_d;
      disp_mode_q <= disp_mode_d;
      disp_dp_q   <= disp_dp_d;
      disp_ovf_q  <= disp_ovf_d;
      div_q       <= div_q + 1'b1;
      idx_q       <= idx_d;
      anodes_q    <= anodes_d;
      segments_q  <= segments_d;
    end
  end

  assign busy     = (state_q == S_CONV);
  assign anodes   = anodes_q;
  assign segments = segments_q;

endmodule
